mmio_bus_arbiter: RTL and testbench

Round-robin arbiter that shares the single FPro MMIO bus (mmio_cs/rd/wr/addr/wr_data/rd_data feeding the MMIO controller and its 64 slots) between NUM_MASTERS requesters, e.g. the processor bridge and a debug/DMA engine. Each master presents a request with command, address and write data. The arbiter grants one master at a time, drives exactly one single-cycle bus access, registers the read data, and returns a one-cycle acknowledge. It sits between the masters and the MMIO controller.

---
 rtl/mmio_bus_arbiter_if.sv | 39 +++
 rtl/mmio_bus_arbiter.sv | 145 ++++++++++++++
 tb/tb_mmio_bus_arbiter.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_bus_arbiter_if.sv
// ============================================================================
// Module : mmio_bus_arbiter_if
// Brief  : Requester-side and MMIO-bus-side signals of the MMIO bus arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mmio_bus_arbiter_if #(
    parameter int NUM_MASTERS = 2
);
    logic [NUM_MASTERS-1:0] m_req;
    logic [NUM_MASTERS-1:0] m_wr;
    logic [20:0]            m_addr    [NUM_MASTERS];
    logic [31:0]            m_wr_data [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] m_ack;
    logic [31:0]            m_rd_data;
    logic                   busy;
    logic                   mmio_cs;
    logic                   mmio_wr;
    logic                   mmio_rd;
    logic [20:0]            mmio_addr;
    logic [31:0]            mmio_wr_data;
    logic [31:0]            mmio_rd_data;

    // master: the arbiter, which owns the MMIO bus; slave: requesters and slots
    modport master (
        input  m_req, m_wr, m_addr, m_wr_data, mmio_rd_data,
        output m_ack, m_rd_data, busy,
        output mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data
    );

    modport slave (
        output m_req, m_wr, m_addr, m_wr_data, mmio_rd_data,
        input  m_ack, m_rd_data, busy,
        input  mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data
    );
endinterface

`default_nettype wire

// File: rtl/mmio_bus_arbiter.sv
// ============================================================================
// Module : mmio_bus_arbiter
// Brief  : Round-robin arbiter granting one single-cycle MMIO access at a time.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mmio_bus_arbiter #(
    parameter int NUM_MASTERS = 2
) (
    input wire                 clk,
    input wire                 reset,
    mmio_bus_arbiter_if.master bus
);

    localparam int IDX_W = $clog2(NUM_MASTERS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [IDX_W-1:0]       r_ptr, w_ptr_nxt;
    logic [IDX_W-1:0]       r_win, w_win_nxt;
    logic [IDX_W-1:0]       w_rr_idx;
    logic [IDX_W:0]         w_cand;
    logic                   w_rr_found;
    logic                   r_cs, w_cs_nxt;
    logic                   r_wr_stb, w_wr_stb_nxt;
    logic                   r_rd_stb, w_rd_stb_nxt;
    logic                   r_busy, w_busy_nxt;
    logic [20:0]            r_addr, w_addr_nxt;
    logic [31:0]            r_wdata, w_wdata_nxt;
    logic [31:0]            r_rd_data, w_rd_data_nxt;
    logic [NUM_MASTERS-1:0] r_ack, w_ack_nxt;

    // First requester at or after r_ptr, searching with wrap-around
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        w_cand     = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_cand = {1'b0, r_ptr} + (IDX_W+1)'(i);
            if (w_cand >= (IDX_W+1)'(NUM_MASTERS)) begin
                w_cand = w_cand - (IDX_W+1)'(NUM_MASTERS);
            end
            if (!w_rr_found && bus.m_req[w_cand[IDX_W-1:0]]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_win_nxt     = r_win;
        w_addr_nxt    = r_addr;
        w_wdata_nxt   = r_wdata;
        w_rd_data_nxt = r_rd_data;
        w_cs_nxt      = 1'b0;
        w_wr_stb_nxt  = 1'b0;
        w_rd_stb_nxt  = 1'b0;
        w_ack_nxt     = '0;
        w_busy_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rr_found) begin
                    w_state_nxt  = S_GRANT;
                    w_win_nxt    = w_rr_idx;
                    w_addr_nxt   = bus.m_addr[w_rr_idx];
                    w_wdata_nxt  = bus.m_wr_data[w_rr_idx];
                    w_cs_nxt     = 1'b1;
                    w_wr_stb_nxt = bus.m_wr[w_rr_idx];
                    w_rd_stb_nxt = ~bus.m_wr[w_rr_idx];
                    w_busy_nxt   = 1'b1;
                end
            end
            S_GRANT: begin
                // The read strobe register doubles as the captured command
                if (r_rd_stb) begin
                    w_rd_data_nxt = bus.mmio_rd_data;
                end
                w_ack_nxt[r_win] = 1'b1;
                w_busy_nxt       = 1'b1;
                w_state_nxt      = S_RESP;
            end
            S_RESP: begin
                w_ptr_nxt   = (r_win == IDX_W'(NUM_MASTERS-1)) ? '0 : r_win + 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr     <= '0;
            r_win     <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rd_data <= '0;
            r_cs      <= 1'b0;
            r_wr_stb  <= 1'b0;
            r_rd_stb  <= 1'b0;
            r_ack     <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_ptr     <= w_ptr_nxt;
            r_win     <= w_win_nxt;
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_rd_data <= w_rd_data_nxt;
            r_cs      <= w_cs_nxt;
            r_wr_stb  <= w_wr_stb_nxt;
            r_rd_stb  <= w_rd_stb_nxt;
            r_ack     <= w_ack_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    assign bus.mmio_cs      = r_cs;
    assign bus.mmio_wr      = r_wr_stb;
    assign bus.mmio_rd      = r_rd_stb;
    assign bus.mmio_addr    = r_addr;
    assign bus.mmio_wr_data = r_wdata;
    assign bus.m_ack        = r_ack;
    assign bus.m_rd_data    = r_rd_data;
    assign bus.busy         = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_mmio_bus_arbiter.sv
// ============================================================================
// Module : tb_mmio_bus_arbiter
// Brief  : Randomized self-checking bench for mmio_bus_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mmio_bus_arbiter;

    localparam int N = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    mmio_bus_arbiter_if #(.NUM_MASTERS(N)) bus ();

    mmio_bus_arbiter #(.NUM_MASTERS(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Transaction-timeline reference: arbitration cycle t -> strobe t+1 -> ack t+2
    int          ptr, win, t_arb, s_cyc, a_cyc, rel_cyc;
    bit          cap_wr;
    logic [20:0] cap_addr, exp_addr;
    logic [31:0] cap_data, exp_wdata, exp_rd, strobe_rdata;

    bit          pend  [N];
    bit          mwr   [N];
    logic [20:0] maddr [N];
    logic [31:0] mdata [N];

    int          raise_pct, rerq_pct, mut_pct;
    bit          rd_fix_en;
    logic [31:0] rd_fix_val;

    logic [N-1:0] ack_q [$];
    int           ackc_q[$];

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic bit pct(input int p);
        return int'($urandom_range(99)) < p;
    endfunction

    task automatic issue(input int i, input bit wr, input logic [20:0] addr, input logic [31:0] data);
        pend[i]  = 1'b1;
        mwr[i]   = wr;
        maddr[i] = addr;
        mdata[i] = data;
    endtask

    task automatic new_req(input int i);
        issue(i, 1'($urandom), 21'($urandom), $urandom);
    endtask

    task automatic model_clear();
        ptr       = 0;
        t_arb     = cyc;
        s_cyc     = -10;
        a_cyc     = -10;
        exp_addr  = '0;
        exp_wdata = '0;
        exp_rd    = '0;
        rel_cyc   = cyc;
    endtask

    task automatic check_outputs();
        logic [N-1:0] exp_ack;
        bit strobe;
        if (cyc == s_cyc) begin
            exp_addr  = cap_addr;
            exp_wdata = cap_data;
        end
        if (cyc == s_cyc + 1 && !cap_wr) exp_rd = strobe_rdata;
        strobe  = (cyc == s_cyc);
        exp_ack = '0;
        if (cyc == a_cyc) exp_ack[win] = 1'b1;
        check_eq("mmio_cs", bus.mmio_cs, strobe);
        check_eq("mmio_wr", bus.mmio_wr, strobe & cap_wr);
        check_eq("mmio_rd", bus.mmio_rd, strobe & !cap_wr);
        check_eq("mmio_addr", bus.mmio_addr, exp_addr);
        check_eq("mmio_wr_data", bus.mmio_wr_data, exp_wdata);
        check_eq("m_ack", bus.m_ack, exp_ack);
        check_eq("m_rd_data", bus.m_rd_data, exp_rd);
        check_eq("busy", bus.busy, (cyc == s_cyc) || (cyc == a_cyc));
        if (bus.m_ack != '0) begin
            ack_q.push_back(bus.m_ack);
            ackc_q.push_back(cyc);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (pend[i] && cyc == a_cyc && win == i) begin
                pend[i] = 1'b0;
                if (pct(rerq_pct)) new_req(i);
            end else if (!pend[i]) begin
                if (pct(raise_pct)) new_req(i);
            end else if (cyc == s_cyc && win == i && pct(mut_pct)) begin
                maddr[i] = 21'($urandom);
                mdata[i] = $urandom;
            end
            bus.m_req[i]     = pend[i];
            bus.m_wr[i]      = mwr[i];
            bus.m_addr[i]    = maddr[i];
            bus.m_wr_data[i] = mdata[i];
        end
        bus.mmio_rd_data = rd_fix_en ? rd_fix_val : $urandom;
        if (cyc == s_cyc) strobe_rdata = bus.mmio_rd_data;
    endtask

    task automatic model_arbitrate();
        bit found;
        found = 1'b0;
        if (cyc >= t_arb) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (ptr + k) % N;
                if (!found && pend[c]) begin
                    found = 1'b1;
                    win   = c;
                end
            end
            if (found) begin
                cap_wr   = mwr[win];
                cap_addr = maddr[win];
                cap_data = mdata[win];
                s_cyc    = cyc + 1;
                a_cyc    = cyc + 2;
                t_arb    = cyc + 3;
                ptr      = (win + 1) % N;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        drive_inputs();
        model_arbitrate();
        @(posedge clk);
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    // Called just after a rising edge; reset hits mid-cycle
    task automatic apply_reset();
        #2 reset = 1'b1;
        #1;
        check_eq("rst_async_cs", bus.mmio_cs, 1'b0);
        check_eq("rst_async_rd", bus.mmio_rd | bus.mmio_wr, 1'b0);
        check_eq("rst_async_ack", bus.m_ack, '0);
        check_eq("rst_async_busy", bus.busy, 1'b0);
        @(negedge clk);
        check_eq("rst_addr", bus.mmio_addr, 21'h0);
        check_eq("rst_wdata", bus.mmio_wr_data, 32'h0);
        check_eq("rst_rd_data", bus.m_rd_data, 32'h0);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        check_outputs();
        drive_inputs();
        model_arbitrate();
        @(posedge clk);
        cyc++;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; mwr[i] = 1'b0; maddr[i] = '0; mdata[i] = '0;
            bus.m_addr[i] = '0; bus.m_wr_data[i] = '0;
        end
        bus.m_req = '0; bus.m_wr = '0; bus.mmio_rd_data = '0;
        raise_pct = 0; rerq_pct = 0; mut_pct = 0;
        rd_fix_en = 1'b0; rd_fix_val = '0;
        cap_wr = 1'b0; cap_addr = '0; cap_data = '0; strobe_rdata = '0; win = 0;
        model_clear();

        @(posedge clk);
        apply_reset();

        // Single read, master 0
        rd_fix_en = 1'b1; rd_fix_val = 32'hDEADBEEF;
        ack_q.delete(); ackc_q.delete();
        issue(0, 1'b0, 21'h000_043, 32'h0);
        run(5);
        #2;
        check_eq("read_rd_data", bus.m_rd_data, 32'hDEADBEEF);
        check_eq("read_ack", ack_q[0], 2'b01);

        // Single write, master 1: read data must hold
        ack_q.delete(); ackc_q.delete();
        issue(1, 1'b1, 21'h000_0A1, 32'h1234_5678);
        run(5);
        #2;
        check_eq("write_rd_hold", bus.m_rd_data, 32'hDEADBEEF);
        check_eq("write_ack", ack_q[0], 2'b10);

        // Pointer: serve master 0, then simultaneous requests favour master 1
        issue(0, 1'b0, 21'h000_123, 32'h0);
        run(5);
        ack_q.delete(); ackc_q.delete();
        issue(0, 1'b0, 21'h000_200, 32'h0);
        issue(1, 1'b1, 21'h000_300, 32'hA5A5_5A5A);
        run(8);
        check_eq("rr_first", ack_q[0], 2'b10);
        check_eq("rr_second", ack_q[1], 2'b01);
        rd_fix_en = 1'b0;

        // Fields changed after capture must not reach the bus
        mut_pct = 100;
        issue(0, 1'b1, 21'h000_155, 32'h0BAD_F00D);
        run(5);
        mut_pct = 0;

        // Reset during GRANT, held request re-served after release
        issue(0, 1'b1, 21'h000_0F0, 32'hCAFE_F00D);
        run(1);
        ack_q.delete(); ackc_q.delete();
        apply_reset();
        run(4);
        check_eq("rstmid_acks", ack_q.size(), 1);
        check_eq("rstmid_ack_cycle", ackc_q[0], rel_cyc + 2);

        // Continuous contention from reset
        raise_pct = 100; rerq_pct = 100;
        ack_q.delete(); ackc_q.delete();
        apply_reset();
        run(62);
        raise_pct = 0; rerq_pct = 0;
        for (int k = 0; k < 20; k++) begin
            logic [N-1:0] e;
            e = '0;
            e[k % N] = 1'b1;
            check_eq("cont_ack", ack_q[k], e);
            check_eq("cont_spacing", ackc_q[k], rel_cyc + 2 + 3 * k);
        end
        run(10);

        // Random traffic with occasional resets
        raise_pct = 30; rerq_pct = 50; mut_pct = 25;
        for (int r = 0; r < 3; r++) begin
            run(250 + int'($urandom_range(6)));
            apply_reset();
        end
        run(200);
        raise_pct = 0; rerq_pct = 0; mut_pct = 0;
        run(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
